// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding and address-field width helpers for the data cache.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: state_t (IDLE, REFILL, WRITE, WR_DONE); word_bits/index_bits/tag_bits helpers.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFILL  = 2'd1,
    WRITE   = 2'd2,
    WR_DONE = 2'd3
  } state_t;

  // Bits selecting a word inside a line.
  function automatic int unsigned word_bits(input int unsigned words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Bits selecting a line.
  function automatic int unsigned index_bits(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  // Remaining upper address bits after byte offset, word and index.
  function automatic int unsigned tag_bits(input int unsigned addr_w,
                                           input int unsigned num_lines,
                                           input int unsigned words_per_line);
    return addr_w - 2 - $clog2(words_per_line) - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage for a direct-mapped cache.
// Latency: combinational read of the selected line; writes take effect on the next rising edge.
// Backpressure: none; writes are accepted every cycle they are enabled.
// Ports: i_clk, i_rst_n (async clear of valid bits only); i_index/i_rd_word select the read
//        word; o_valid/o_tag/o_rdata return the line state; i_data_we/i_wr_word/i_wdata write
//        one word of line i_index; i_fill_done/i_fill_tag mark line i_index valid with a new tag.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned WORD_BITS  = word_bits(4),
  parameter int unsigned INDEX_BITS = index_bits(16),
  parameter int unsigned TAG_BITS   = tag_bits(32, 16, 4)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [INDEX_BITS-1:0] i_index,
  input  logic [WORD_BITS-1:0]  i_rd_word,
  output logic                  o_valid,
  output logic [TAG_BITS-1:0]   o_tag,
  output logic [31:0]           o_rdata,
  input  logic                  i_data_we,
  input  logic [WORD_BITS-1:0]  i_wr_word,
  input  logic [31:0]           i_wdata,
  input  logic                  i_fill_done,
  input  logic [TAG_BITS-1:0]   i_fill_tag
);

  localparam int unsigned LINES = 2 ** INDEX_BITS;
  localparam int unsigned WORDS = 2 ** WORD_BITS;

  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [31:0]         r_data [LINES][WORDS];

  // Only the valid bits need clearing; tag and data are qualified by them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_fill_done) begin
      r_valid[i_index] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_fill_done) begin
      r_tag[i_index] <= i_fill_tag;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_data_we) begin
      r_data[i_index][i_wr_word] <= i_wdata;
    end
  end

  assign o_valid = r_valid[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_rdata = r_data[i_index][i_rd_word];

endmodule

// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl: direct-mapped, write-through, no-write-allocate data cache controller.
// Latency: read hit 0 cycles; miss = WORDS_PER_LINE memory handshakes + 1; store = 1 handshake + 1.
// Backpressure: stall freezes the core while refilling or writing through; memory paced by mem_ready.
// Ports: clk, reset (async, active-low); core side cpu_rd/cpu_wr/cpu_addr/cpu_wdata -> cpu_rdata,
//        stall; memory side mem_req/mem_we/mem_addr/mem_wdata -> mem_rdata/mem_ready.
// Optional: define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module data_cache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES      = 16,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned WORD_BITS  = word_bits(WORDS_PER_LINE);
  localparam int unsigned INDEX_BITS = index_bits(NUM_LINES);
  localparam int unsigned TAG_BITS   = tag_bits(ADDR_W, NUM_LINES, WORDS_PER_LINE);
  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(WORDS_PER_LINE - 1);

  state_t                r_state, w_next;
  logic [WORD_BITS-1:0]  r_cnt;

  logic [WORD_BITS-1:0]  w_word;
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_valid, w_hit, w_is_rd, w_is_wr;
  logic [TAG_BITS-1:0]   w_line_tag;
  logic [31:0]           w_arr_rdata;
  logic                  w_data_we, w_fill_done, w_refill_ack, w_stall;
  logic [WORD_BITS-1:0]  w_wr_word;
  logic [31:0]           w_wdata;
  logic                  w_unused;

  assign w_word   = cpu_addr[2 +: WORD_BITS];
  assign w_index  = cpu_addr[2 + WORD_BITS +: INDEX_BITS];
  assign w_tag    = cpu_addr[ADDR_W-1 -: TAG_BITS];
  assign w_unused = ^cpu_addr[1:0];

  // A simultaneous load and store is handled as a store.
  assign w_is_wr = cpu_wr;
  assign w_is_rd = cpu_rd && !cpu_wr;
  assign w_hit   = w_valid && (w_line_tag == w_tag);

  dcache_array #(
    .WORD_BITS  (WORD_BITS),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_index     (w_index),
    .i_rd_word   (w_word),
    .o_valid     (w_valid),
    .o_tag       (w_line_tag),
    .o_rdata     (w_arr_rdata),
    .i_data_we   (w_data_we),
    .i_wr_word   (w_wr_word),
    .i_wdata     (w_wdata),
    .i_fill_done (w_fill_done),
    .i_fill_tag  (w_tag)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_fill_done) begin
        r_cnt <= '0;
      end else if (w_refill_ack) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_stall      = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    w_data_we    = 1'b0;
    w_wr_word    = r_cnt;
    w_wdata      = mem_rdata;
    w_fill_done  = 1'b0;
    w_refill_ack = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_is_wr) begin
          w_stall = 1'b1;
          w_next  = WRITE;
        end else if (w_is_rd && !w_hit) begin
          w_stall = 1'b1;
          w_next  = REFILL;
        end
      end
      REFILL: begin
        // Always fills from word 0; the held load replays as a hit in IDLE.
        w_stall  = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {w_tag, w_index, r_cnt, 2'b00};
        if (mem_ready) begin
          w_refill_ack = 1'b1;
          w_data_we    = 1'b1;
          if (r_cnt == LAST_WORD) begin
            w_fill_done = 1'b1;
            w_next      = IDLE;
          end
        end
      end
      WRITE: begin
        w_stall   = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {cpu_addr[ADDR_W-1:2], 2'b00};
        mem_wdata = cpu_wdata;
        w_wr_word = w_word;
        w_wdata   = cpu_wdata;
        if (mem_ready) begin
          // Update the cached copy only when the line is resident: no write allocate.
          w_data_we = w_hit;
          w_next    = WR_DONE;
        end
      end
      WR_DONE: begin
        // One unstalled cycle lets the core retire the store; inputs are ignored here.
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State is already IDLE under reset; these gate the input-dependent outputs too.
  assign stall     = reset & w_stall;
  assign cpu_rdata = reset ? w_arr_rdata : 32'h0;

`ifdef DCACHE_STATS_EN
  logic        r_replay;
  logic [31:0] r_hit_count, r_miss_count;
  logic        w_hit_evt, w_miss_evt;

  // The first IDLE cycle after a refill is the replay of the missed load, not a new hit.
  assign w_hit_evt  = (r_state == IDLE) && w_is_rd && w_hit && !r_replay;
  assign w_miss_evt = (r_state == IDLE) && (w_next == REFILL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_replay     <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_replay <= w_fill_done;
      if (w_hit_evt && (r_hit_count != '1)) begin
        r_hit_count <= r_hit_count + 1'b1;
      end
      if (w_miss_evt && (r_miss_count != '1)) begin
        r_miss_count <= r_miss_count + 1'b1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// tb_data_cache_ctrl: directed bench for data_cache_ctrl with a word-serial memory responder.
// Latency: responder answers each request after a programmable number of cycles (0 = same cycle).
// Backpressure: the responder holds mem_ready low until its delay expires.
module tb_data_cache_ctrl;

  logic        clk;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  int checks   = 0;
  int failures = 0;
  int lat      = 2;
  int wait_cnt = 0;

  logic [31:0] log_addr [$];
  logic        log_we   [$];
  logic [31:0] log_dat  [$];
  logic [31:0] wmem     [logic [31:0]];

  data_cache_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (wmem.exists(a)) return wmem[a];
    return 32'hC0DE_0000 + a;
  endfunction

  // Memory responder: acts on falling edges so the DUT samples mem_ready at the next rising edge.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_req === 1'b1) begin
        wait_cnt++;
        if (wait_cnt > lat) begin
          wait_cnt = 0;
          log_addr.push_back(mem_addr);
          log_we.push_back(mem_we);
          log_dat.push_back(mem_wdata);
          if (mem_we) wmem[mem_addr] = mem_wdata;
          mem_rdata = mem_val(mem_addr);
          mem_ready = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_dat.delete();
  endtask

  task automatic wait_unstall(input int max_cyc);
    int n = 0;
    while (stall === 1'b1 && n < max_cyc) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("unstall_timeout", stall, 1'b0);
  endtask

  initial begin
    reset     = 1'b0;
    cpu_rd    = 1'b1;
    cpu_wr    = 1'b0;
    cpu_addr  = 32'h100;
    cpu_wdata = 32'h0;
    lat       = 2;

    // Reset holds outputs quiet even with a load pending.
    repeat (2) @(negedge clk);
    #2;
    chk("rst_stall", stall, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);

    // 1: cold miss on 0x100, four word reads then replay hit.
    @(negedge clk);
    #1 reset = 1'b1;
    clear_log();
    #1;
    chk("t1_stall", stall, 1'b1);
    wait_unstall(60);
    chk("t1_nreq", log_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_addr.size()) begin
        chk("t1_addr", log_addr[i], 32'h100 + 32'(4 * i));
        chk("t1_we", log_we[i], 1'b0);
      end
    end
    chk("t1_rdata", cpu_rdata, mem_val(32'h100));
    chk("t1_mem_req", mem_req, 1'b0);

    // 2: hit on 0x104, no stall, no memory activity.
    cpu_addr = 32'h104;
    #1;
    chk("t2_stall", stall, 1'b0);
    chk("t2_rdata", cpu_rdata, mem_val(32'h104));
    chk("t2_mem_req", mem_req, 1'b0);
    @(negedge clk);
    #2;
    chk("t2_nreq", log_addr.size(), 4);

    // 3: write hit to 0x108.
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b1;
    cpu_addr  = 32'h108;
    cpu_wdata = 32'hDEADBEEF;
    clear_log();
    #1;
    chk("t3_stall", stall, 1'b1);
    wait_unstall(60);
    chk("t3_nreq", log_addr.size(), 1);
    if (log_addr.size() > 0) begin
      chk("t3_addr", log_addr[0], 32'h108);
      chk("t3_we", log_we[0], 1'b1);
      chk("t3_wdata", log_dat[0], 32'hDEADBEEF);
    end
    chk("t3_wrdone_req", mem_req, 1'b0);
    // Store still asserted: the unstalled cycle lasts exactly one cycle.
    @(negedge clk);
    #2;
    chk("t3_restall", stall, 1'b1);
    wait_unstall(60);
    cpu_wr = 1'b0;
    cpu_rd = 1'b1;
    #1;
    chk("t3_wrdone_ignore", stall, 1'b0);
    chk("t3_nreq2", log_addr.size(), 2);
    @(negedge clk);
    #2;
    chk("t3_hit_stall", stall, 1'b0);
    chk("t3_hit_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t3_hit_req", mem_req, 1'b0);

    // 4: conflict miss on 0x200 with same-cycle ready, then 0x100 misses again.
    lat      = 0;
    cpu_addr = 32'h200;
    clear_log();
    #1;
    chk("t4_stall", stall, 1'b1);
    wait_unstall(60);
    chk("t4_nreq", log_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_addr.size()) chk("t4_addr", log_addr[i], 32'h200 + 32'(4 * i));
    end
    chk("t4_rdata", cpu_rdata, mem_val(32'h200));
    lat      = 2;
    cpu_addr = 32'h100;
    clear_log();
    #1;
    chk("t4_evict_stall", stall, 1'b1);
    wait_unstall(60);
    chk("t4_evict_nreq", log_addr.size(), 4);
    if (log_addr.size() > 0) chk("t4_evict_addr0", log_addr[0], 32'h100);
    chk("t4_evict_rdata", cpu_rdata, mem_val(32'h100));
    cpu_addr = 32'h108;
    #1;
    chk("t4_wt_stall", stall, 1'b0);
    chk("t4_wt_rdata", cpu_rdata, 32'hDEADBEEF);

    // 5: write miss to 0x300, no allocation.
    lat       = 1;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b1;
    cpu_addr  = 32'h300;
    cpu_wdata = 32'h12345678;
    clear_log();
    #1;
    chk("t5_stall", stall, 1'b1);
    wait_unstall(60);
    chk("t5_nreq", log_addr.size(), 1);
    if (log_addr.size() > 0) begin
      chk("t5_addr", log_addr[0], 32'h300);
      chk("t5_we", log_we[0], 1'b1);
    end
    cpu_wr = 1'b0;
    cpu_rd = 1'b1;
    clear_log();
    @(negedge clk);
    #2;
    chk("t5_rd_miss", stall, 1'b1);
    wait_unstall(60);
    chk("t5_rd_nreq", log_addr.size(), 4);
    chk("t5_rd_rdata", cpu_rdata, 32'h12345678);

    // 6: reset in the middle of a refill.
    lat      = 2;
    cpu_addr = 32'h100;
    clear_log();
    #1;
    chk("t6_stall", stall, 1'b1);
    for (int n = 0; n < 60 && log_addr.size() < 2; n++) begin
      @(negedge clk);
      #2;
    end
    chk("t6_two_words", log_addr.size(), 2);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_req", mem_req, 1'b0);
    chk("t6_rst_stall", stall, 1'b0);
    chk("t6_rst_rdata", cpu_rdata, 32'h0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    clear_log();
    #1;
    chk("t6_post_miss", stall, 1'b1);
    wait_unstall(60);
    chk("t6_nreq", log_addr.size(), 4);
    if (log_addr.size() > 0) chk("t6_addr0", log_addr[0], 32'h100);
    chk("t6_rdata", cpu_rdata, mem_val(32'h100));

    cpu_rd = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
